// File: rtl/tpu_sync_fifo.sv
// tpu_sync_fifo: single-clock FIFO between the memory-side supplier and the systolic-array feeder.
// Ports: clk, rst (async, active-high), clear (sync flush of data and error flags),
//   w_en/din push, r_en pop with registered dout and one-cycle dout_valid,
//   full/almost_full/empty/count occupancy status, sticky overflow/underflow errors.
module tpu_sync_fifo #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     w_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     r_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     almost_full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF = AF_LEVEL[AW:0];
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic push, pop;
  // pointers carry an extra wrap bit so full and empty are distinguishable
  assign empty       = wr_ptr == rd_ptr;
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count       = wr_ptr - rd_ptr;
  assign almost_full = count >= AF;
  assign push        = w_en && !full && !clear;
  assign pop         = r_en && !empty && !clear;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop) begin
        dout   <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + ONE;
      end
      dout_valid <= pop;
      if (w_en && full) overflow <= 1'b1;
      if (r_en && empty) underflow <= 1'b1;
    end
endmodule

// File: tb/tb_tpu_sync_fifo.sv
// tb_tpu_sync_fifo: directed scoreboard bench for tpu_sync_fifo (DEPTH=8, WIDTH=16, AF_LEVEL=6).
module tb_tpu_sync_fifo;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        w_en = 1'b0;
  logic [15:0] din = '0;
  logic        r_en = 1'b0;
  logic [15:0] dout;
  logic        dout_valid, full, almost_full, empty, overflow, underflow;
  logic [3:0]  count;
  int          pass_cnt = 0;
  int          total = 0;
  logic [15:0] expq[$];

  tpu_sync_fifo #(.WIDTH(16), .DEPTH(8), .AF_LEVEL(6)) dut (
    .clk(clk), .rst(rst), .clear(clear), .w_en(w_en), .din(din), .r_en(r_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .almost_full(almost_full),
    .empty(empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  // monitor: every popped word must match the oldest expected word
  always @(negedge clk) begin
    logic [15:0] e;
    if (dout_valid === 1'b1) begin
      if (expq.size() == 0) chk("unexpected_pop", {16'h0, dout}, 32'hFFFF_FFFF);
      else begin
        e = expq.pop_front();
        chk("dout", {16'h0, dout}, {16'h0, e});
      end
    end
  end

  task automatic step(input logic w, input logic [15:0] d, input logic r, input logic c = 1'b0);
    w_en = w; din = d; r_en = r; clear = c;
    @(posedge clk);
    #1;
    w_en = 1'b0; r_en = 1'b0; clear = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_count", count, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dv", dout_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    rst = 1'b0;
    // fill
    for (int i = 1; i <= 8; i++) begin
      step(1, 16'(i), 0);
      chk("fill_count", count, i);
      chk("fill_af", almost_full, i >= 6);
    end
    chk("fill_full", full, 1);
    // overflow
    step(1, 16'hDEAD, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 8);
    // drain
    for (int i = 1; i <= 8; i++) begin
      expq.push_back(16'(i));
      step(0, 0, 1);
    end
    chk("drain_empty", empty, 1);
    step(0, 0, 0);
    chk("idle_dv", dout_valid, 0);
    chk("idle_dout_hold", dout, 16'h0008);
    step(0, 0, 0, 1);
    chk("clr_ovf", overflow, 0);
    chk("clr_empty", empty, 1);
    // simultaneous on empty
    step(1, 16'h00AA, 1);
    chk("unf_flag", underflow, 1);
    chk("unf_count", count, 1);
    chk("unf_dv", dout_valid, 0);
    expq.push_back(16'h00AA);
    step(0, 0, 1);
    chk("unf_empty", empty, 1);
    step(0, 0, 0, 1);
    chk("clr_unf", underflow, 0);
    // simultaneous on full
    for (int i = 0; i < 8; i++) step(1, 16'h0200 + 16'(i), 0);
    chk("full2", full, 1);
    expq.push_back(16'h0200);
    step(1, 16'h0BAD, 1);
    chk("fullsim_count", count, 7);
    chk("fullsim_ovf", overflow, 1);
    for (int i = 1; i < 8; i++) begin
      expq.push_back(16'h0200 + 16'(i));
      step(0, 0, 1);
    end
    chk("fullsim_empty", empty, 1);
    step(0, 0, 0, 1);
    // wrap-around streaming
    for (int i = 0; i < 3; i++) step(1, 16'h0100 + 16'(i), 0);
    for (int k = 0; k < 40; k++) begin
      expq.push_back(16'h0100 + 16'(k));
      step(1, 16'h0103 + 16'(k), 1);
      chk("stream_count", count, 3);
    end
    for (int i = 0; i < 3; i++) begin
      expq.push_back(16'h0128 + 16'(i));
      step(0, 0, 1);
    end
    chk("stream_empty", empty, 1);
    // async reset mid-stream
    for (int i = 0; i < 5; i++) step(1, 16'h0300 + 16'(i), 0);
    chk("pre_rst_count", count, 5);
    #2 rst = 1'b1;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_count", count, 0);
    chk("arst_dout", dout, 0);
    #1 rst = 1'b0;
    step(1, 16'h1234, 0);
    expq.push_back(16'h1234);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("scoreboard_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
